mtx_iq_framer: RTL and testbench

//  Downstream stage of the multitone DDS signal generator. Takes the sin/cos sample stream and applies
//  a fixed-point gain with round and saturate. Drops samples until a sync-aligned symbol boundary, then

---
 rtl/mtx_iq_framer_pkg.sv | 29 ++
 rtl/mtx_iq_gain_sat.sv | 23 ++
 rtl/mtx_iq_framer.sv | 105 ++++++++++
 tb/tb_mtx_iq_framer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mtx_iq_framer_pkg.sv
// Shared constants, FSM encoding and the round/saturate helper for the I/Q framer.
package mtx_iq_framer_pkg;
  localparam int SC_W      = 16;
  localparam int GAIN_W    = 16;
  localparam int GAIN_FRAC = 14;
  localparam int SPP_W     = 16;
  localparam int PROD_W    = SC_W + GAIN_W;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic signed [PROD_W:0] RND     = (PROD_W+1)'(1 << (GAIN_FRAC-1));
  localparam logic signed [PROD_W:0] SAT_MAX = (PROD_W+1)'((1 << (SC_W-1)) - 1);
  localparam logic signed [PROD_W:0] SAT_MIN = -SAT_MAX;

  // Round half up then clamp symmetrically, so -full-scale never appears.
  function automatic logic signed [SC_W-1:0] sat_round(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] r;
    r = $signed({p[PROD_W-1], p}) + RND;
    r = r >>> GAIN_FRAC;
    if (r > SAT_MAX)      return $signed(SAT_MAX[SC_W-1:0]);
    else if (r < SAT_MIN) return $signed(SAT_MIN[SC_W-1:0]);
    else                  return $signed(r[SC_W-1:0]);
  endfunction
endpackage

// File: rtl/mtx_iq_gain_sat.sv
// One I/Q component: stage 1 multiply, stage 2 round/saturate into the output register.
module mtx_iq_gain_sat
  import mtx_iq_framer_pkg::*;
(
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     ce,
  input  logic signed [SC_W-1:0]   din,
  input  logic signed [GAIN_W-1:0] gain,
  output logic signed [SC_W-1:0]   dout
);
  logic signed [PROD_W-1:0] prod;

  always_ff @(posedge clk) begin
    if (clr) begin
      prod <= '0;
      dout <= '0;
    end else if (ce) begin
      prod <= din * gain;
      dout <= sat_round(prod);
    end
  end
endmodule

// File: rtl/mtx_iq_framer.sv
// Gain/saturate the DDS sin/cos stream, wait for a sync-aligned symbol edge, then frame into packets.
module mtx_iq_framer
  import mtx_iq_framer_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     srst,
  input  logic                     enable,
  input  logic signed [GAIN_W-1:0] gain,
  input  logic [SPP_W-1:0]         spp,
  input  logic                     sync_ready,
  input  logic [2*SC_W-1:0]        in_tdata,
  input  logic                     in_tvalid,
  input  logic                     in_tlast,
  output logic                     in_tready,
  output logic [2*SC_W-1:0]        out_tdata,
  output logic                     out_tvalid,
  output logic                     out_tlast,
  output logic                     out_tuser,
  input  logic                     out_tready,
  output logic                     busy,
  output logic [15:0]              pkt_count
);
  logic                     clr, adv, pass, acc, take, last_idx, first;
  logic [1:0]               state;
  logic [SPP_W-1:0]         spp_l, idx, idx_nxt;
  logic signed [GAIN_W-1:0] gain_l, gain_cur;
  logic [2:1]               vld_pipe, last_pipe, user_pipe;
  logic signed [SC_W-1:0]   i_out, q_out;

  assign clr       = ~resetn | srst;
  assign adv       = out_tready | ~out_tvalid;
  assign pass      = (state == S_RUN) || (state == S_DRAIN);
  assign in_tready = pass ? adv : 1'b1;
  assign acc       = in_tvalid & in_tready;
  assign take      = acc & pass;
  assign last_idx  = (idx == spp_l - 1'b1);
  assign idx_nxt   = last_idx ? '0 : idx + 1'b1;
  // The opening beat of a packet uses the live gain; the rest reuse its latched copy.
  assign gain_cur  = (idx == '0) ? gain : gain_l;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      spp_l  <= SPP_W'(1);
      idx    <= '0;
      gain_l <= GAIN_UNITY;
      first  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (enable) state <= S_ARMED;
        S_ARMED: begin
          if (!enable) state <= S_IDLE;
          else if (acc && in_tlast && sync_ready) begin
            state <= S_RUN;
            spp_l <= (spp == '0) ? SPP_W'(1) : spp;
            idx   <= '0;
            first <= 1'b1;
          end
        end
        // Leaving RUN: go idle only if no packet remains open after this cycle.
        S_RUN:   if (!enable) state <= ((take ? idx_nxt : idx) == '0) ? S_IDLE : S_DRAIN;
        S_DRAIN: if (take && last_idx) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (take) begin
        idx   <= idx_nxt;
        first <= 1'b0;
        if (idx == '0) gain_l <= gain;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      user_pipe <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[1], take};
      last_pipe <= {last_pipe[1], take & last_idx};
      user_pipe <= {user_pipe[1], take & first};
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                                   pkt_count <= '0;
    else if (out_tvalid && out_tready && out_tlast) pkt_count <= pkt_count + 1'b1;
  end

  mtx_iq_gain_sat u_i (
    .clk(clk), .clr(clr), .ce(adv),
    .din($signed(in_tdata[SC_W-1:0])), .gain(gain_cur), .dout(i_out)
  );
  mtx_iq_gain_sat u_q (
    .clk(clk), .clr(clr), .ce(adv),
    .din($signed(in_tdata[2*SC_W-1:SC_W])), .gain(gain_cur), .dout(q_out)
  );

  assign out_tdata  = {i_out, q_out};
  assign out_tvalid = vld_pipe[2];
  assign out_tlast  = last_pipe[2];
  assign out_tuser  = user_pipe[2];
  assign busy       = (state != S_IDLE);
endmodule

// File: tb/tb_mtx_iq_framer.sv
// Randomised bench: bursts are scored against a per-burst list of expected beats built from the rules.
module tb_mtx_iq_framer;
  logic        clk = 1'b0;
  logic        resetn, srst, enable, sync_ready, in_tvalid, in_tlast, out_tready;
  logic [15:0] gain, spp;
  logic [31:0] in_tdata;
  logic        in_tready, out_tvalid, out_tlast, out_tuser, busy;
  logic [31:0] out_tdata;
  logic [15:0] pkt_count;

  int n_cmp = 0, n_bad = 0, exp_pkts = 0, rmode = 0;
  bit acc;
  logic [33:0] q[$];

  always #5 clk = ~clk;

  mtx_iq_framer dut (
    .clk(clk), .resetn(resetn), .srst(srst), .enable(enable), .gain(gain), .spp(spp),
    .sync_ready(sync_ready), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tuser(out_tuser), .out_tready(out_tready), .busy(busy), .pkt_count(pkt_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference gain: exact product, +half LSB, floor divide, symmetric clamp.
  function automatic int sat_m(input int d, input int g);
    longint r;
    r = longint'(d) * longint'(g) + 8192;
    r = (r >= 0) ? r / 16384 : -((-r + 16383) / 16384);
    if (r > 32767)  r = 32767;
    if (r < -32767) r = -32767;
    return int'(r);
  endfunction

  // Sample ahead of the rising edge, then move to the falling edge where inputs change.
  task automatic tick();
    logic [33:0] e;
    #2;
    acc = in_tvalid && in_tready;
    if (out_tvalid && out_tready) begin
      if (q.size() == 0) chk("extra_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("beat", {out_tdata, out_tlast, out_tuser}, e);
      end
    end
    @(negedge clk);
    out_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic offer_until_acc(input logic last, input logic sync);
    int to = 0;
    in_tvalid = 1'b1; in_tlast = last; sync_ready = sync; in_tdata = $urandom;
    do begin tick(); to++; end while (!acc && to < 100);
    if (!acc) chk("arm_timeout", 1, 0);
  endtask

  task automatic burst(input int sppv, input int m, input int gmode, input int gfix,
                       input int dmode, input int dfix, input int rm, input bit junk);
    int se, np, n, k, to;
    bit dropped;
    logic signed [15:0] cs[], sn[], gp[];
    logic [15:0] iv, qv;
    se = (sppv == 0) ? 1 : sppv;
    np = (m + se - 1) / se;
    n  = np * se;
    cs = new[n]; sn = new[n]; gp = new[np];
    for (int p = 0; p < np; p++) gp[p] = (gmode == 0) ? 16'(gfix) : 16'($urandom);
    for (int j = 0; j < n; j++) begin
      cs[j] = (dmode == 0) ? 16'(dfix) : ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
      sn[j] = (dmode == 0) ? 16'(dfix) : 16'($urandom);
      iv = 16'(sat_m(int'(cs[j]), int'(gp[j / se])));
      qv = 16'(sat_m(int'(sn[j]), int'(gp[j / se])));
      q.push_back({iv, qv, (j % se) == se - 1, j == 0});
    end
    rmode = rm; spp = 16'(sppv); gain = 16'($urandom); enable = 1'b1; in_tvalid = 1'b0;
    tick();
    if (junk) begin
      offer_until_acc(1'b1, 1'b0);
      for (int j = 0; j < 3; j++) offer_until_acc(1'b0, 1'b1);
    end
    offer_until_acc(1'b1, 1'b1);
    sync_ready = 1'b0;
    k = 0; to = 0; dropped = 0;
    while (k < n && to < 20000) begin
      to++;
      if (k == m && !dropped) begin
        enable = 1'b0; in_tvalid = 1'b0; dropped = 1;
        tick();
        continue;
      end
      in_tvalid = 1'b1; in_tlast = 1'($urandom);
      in_tdata  = {sn[k], cs[k]};
      gain      = (k % se == 0) ? gp[k / se] : 16'($urandom);
      spp       = 16'($urandom);
      tick();
      if (acc) k++;
    end
    enable = 1'b0; in_tvalid = 1'b0;
    to = 0;
    do begin tick(); to++; end while ((q.size() > 0 || busy) && to < 300);
    if (to >= 300) chk("drain_timeout", 1, 0);
    exp_pkts += np;
    chk("pkt_count", 64'(pkt_count), 64'(16'(exp_pkts)));
    chk("busy_end", 64'(busy), 0);
  endtask

  initial begin
    resetn = 1'b0; srst = 1'b0; enable = 1'b0; sync_ready = 1'b0; in_tvalid = 1'b0;
    in_tlast = 1'b0; out_tready = 1'b1; gain = 16'd16384; spp = 16'd4; in_tdata = '0;
    @(negedge clk); tick(); tick();
    chk("rst_tvalid", 64'(out_tvalid), 0);
    chk("rst_tdata", 64'({out_tdata, out_tlast, out_tuser}), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pkt", 64'(pkt_count), 0);
    chk("rst_tready", 64'(in_tready), 1);
    resetn = 1'b1;

    burst(4, 8, 0, 16384, 0, 1000, 0, 0);
    burst(1, 1, 0, 8192, 0, 3, 0, 0);
    burst(1, 1, 0, 32767, 0, -32768, 0, 0);
    burst(1, 1, 0, 16384, 0, -32768, 0, 0);
    burst(1, 1, 0, -16384, 0, -32768, 0, 0);
    burst(1, 1, 0, 32767, 0, 20000, 0, 0);
    burst(0, 3, 0, 16384, 1, 0, 1, 0);
    burst(8, 4, 1, 0, 1, 0, 1, 1);
    burst(3, 6, 1, 0, 1, 0, 1, 1);
    burst($urandom_range(2, 7), 1000, 1, 0, 1, 0, 1, 1);

    // Mid-burst reset with the output stalled: in-flight beats must vanish.
    rmode = 2; spp = 16'd4; gain = 16'd16384; enable = 1'b1; in_tvalid = 1'b0;
    tick();
    offer_until_acc(1'b1, 1'b1);
    sync_ready = 1'b0; in_tlast = 1'b0;
    for (int j = 0; j < 4; j++) begin in_tdata = $urandom; tick(); end
    chk("pre_rst_valid", 64'(out_tvalid), 1);
    resetn = 1'b0;
    tick();
    #1;
    chk("mid_rst_valid", 64'(out_tvalid), 0);
    chk("mid_rst_pkt", 64'(pkt_count), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    resetn = 1'b1; enable = 1'b0; in_tvalid = 1'b0; rmode = 0;
    q.delete(); exp_pkts = 0;
    tick();

    burst(3, 5, 1, 0, 1, 0, 1, 0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    #1;
    chk("srst_pkt", 64'(pkt_count), 0);
    chk("srst_tvalid", 64'(out_tvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
